// File: rtl/bist_session_scheduler_if.sv
// Shared BIST monitor link: routing select and monitor reset go out, done/signature come back.
interface bist_session_scheduler_if #(
  parameter int CORE_IDX_W = 2,
  parameter int SIG_WIDTH  = 16
);
  logic                  monRst;
  logic [CORE_IDX_W-1:0] coreSel;
  logic                  monDone;
  logic [SIG_WIDTH-1:0]  monSig;

  modport master (output monRst, coreSel, input monDone, monSig);
  modport slave  (input monRst, coreSel, output monDone, monSig);
endinterface

// File: rtl/bist_session_scheduler.sv
// Campaign controller: walks enabled cores over one shared SRSG/SISR datapath,
// runs the monitor per core and accumulates pass/timeout result masks.
module bist_session_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int CORE_IDX_W = 2,
  parameter int SIG_WIDTH  = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                           clk,
  input  logic                           rstIn,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           coreMask,
  input  logic [NUM_CORES*SIG_WIDTH-1:0] goldenSig,
  bist_session_scheduler_if.master       mon,
  output logic                           busy,
  output logic                           campaignDone,
  output logic [NUM_CORES-1:0]           passMask,
  output logic [NUM_CORES-1:0]           timeoutMask,
  output logic [SIG_WIDTH-1:0]           sigCapture
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, RESET_MON, RUN, CAPTURE, NEXT
  } stateT;

  stateT                 state, stateNext;
  logic [CORE_IDX_W-1:0] idx;
  logic [CORE_IDX_W-1:0] coreSelReg;
  logic [NUM_CORES-1:0]  maskReg;
  logic [TIMER_W-1:0]    timer;
  logic                  rstCnt;
  logic                  monRstDec;
  logic                  lastIdx;
  logic                  timerEnd;

  assign lastIdx     = (idx == CORE_IDX_W'(NUM_CORES - 1));
  assign timerEnd    = (timer == TIMER_W'(TIMEOUT - 1));
  assign mon.coreSel = coreSelReg;
  assign mon.monRst  = monRstDec;

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    monRstDec = 1'b1;
    busy      = (state != IDLE);
    case (state)
      IDLE:      if (start) stateNext = SCAN;
      SCAN: begin
        if (maskReg[idx])  stateNext = RESET_MON;
        else if (lastIdx)  stateNext = IDLE;
      end
      RESET_MON: if (rstCnt) stateNext = RUN;
      RUN: begin
        monRstDec = 1'b0;
        // done wins over a timeout landing in the same cycle
        if (mon.monDone)   stateNext = CAPTURE;
        else if (timerEnd) stateNext = NEXT;
      end
      CAPTURE: begin
        monRstDec = 1'b0;
        stateNext = NEXT;
      end
      NEXT:      stateNext = lastIdx ? IDLE : SCAN;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      idx          <= '0;
      coreSelReg   <= '0;
      maskReg      <= '0;
      timer        <= '0;
      rstCnt       <= 1'b0;
      campaignDone <= 1'b0;
      passMask     <= '0;
      timeoutMask  <= '0;
      sigCapture   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          maskReg      <= coreMask;
          passMask     <= '0;
          timeoutMask  <= '0;
          campaignDone <= 1'b0;
          idx          <= '0;
        end
        SCAN: begin
          coreSelReg <= idx;
          if (maskReg[idx])  rstCnt       <= 1'b0;
          else if (lastIdx)  campaignDone <= 1'b1;
          else               idx          <= idx + CORE_IDX_W'(1);
        end
        RESET_MON: begin
          rstCnt <= 1'b1;
          if (rstCnt) timer <= '0;
        end
        RUN: begin
          timer <= timer + TIMER_W'(1);
          if (!mon.monDone && timerEnd) timeoutMask[idx] <= 1'b1;
        end
        CAPTURE: begin
          sigCapture    <= mon.monSig;
          passMask[idx] <= (mon.monSig == goldenSig[idx*SIG_WIDTH +: SIG_WIDTH]);
        end
        NEXT: begin
          if (lastIdx) campaignDone <= 1'b1;
          else         idx          <= idx + CORE_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Scoreboard bench: directed campaigns push expected monitor runs and campaign results;
// a negedge monitor pops and compares as the DUT presents them.
module tb_bist_session_scheduler;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int SW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rstIn;
  logic            start;
  logic [NC-1:0]   coreMask;
  logic [NC*SW-1:0] goldenSig;
  logic            busy;
  logic            campaignDone;
  logic [NC-1:0]   passMask;
  logic [NC-1:0]   timeoutMask;
  logic [SW-1:0]   sigCapture;

  int checks = 0;
  int errors = 0;

  typedef struct { int sel; int len; } runT;
  typedef struct { logic [NC-1:0] pass; logic [NC-1:0] tmo; logic [SW-1:0] sig; int busyCyc; } campT;
  runT  runQ[$];
  campT campQ[$];

  int            doneAt[NC];   // RUN cycle in which the fake monitor raises done; 0 = never
  logic [SW-1:0] sigVal[NC];

  bist_session_scheduler_if #(.CORE_IDX_W(IW), .SIG_WIDTH(SW)) ifc ();

  bist_session_scheduler #(
    .NUM_CORES(NC), .CORE_IDX_W(IW), .SIG_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstIn(rstIn), .start(start), .coreMask(coreMask), .goldenSig(goldenSig),
    .mon(ifc), .busy(busy), .campaignDone(campaignDone), .passMask(passMask),
    .timeoutMask(timeoutMask), .sigCapture(sigCapture)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural monitor: counts cycles out of reset, raises done at doneAt[coreSel]
  initial begin : fakeMon
    int cnt;
    cnt = 0;
    ifc.monDone = 1'b0;
    ifc.monSig  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rstIn || ifc.monRst) cnt = 0;
      else                     cnt++;
      if (cnt > 0 && doneAt[ifc.coreSel] > 0 && cnt >= doneAt[ifc.coreSel]) begin
        ifc.monDone = 1'b1;
        ifc.monSig  = sigVal[ifc.coreSel];
      end else begin
        ifc.monDone = 1'b0;
        ifc.monSig  = 16'hDEAD;
      end
    end
  end

  initial begin : scoreboard
    int   lowCnt;
    int   lowSel;
    int   busyCnt;
    logic prevDone;
    runT  r;
    campT c;
    lowCnt = 0; lowSel = 0; busyCnt = 0; prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (rstIn) begin
        lowCnt = 0; busyCnt = 0; prevDone = 1'b0;
      end else begin
        if (!ifc.monRst) begin
          if (lowCnt == 0) lowSel = int'(ifc.coreSel);
          else chk("coreSelStableInRun", 64'(ifc.coreSel), 64'(lowSel));
          lowCnt++;
        end else if (lowCnt > 0) begin
          chk("runExpected", 64'(runQ.size() != 0), 64'd1);
          if (runQ.size() != 0) begin
            r = runQ.pop_front();
            chk("runCoreSel", 64'(lowSel), 64'(r.sel));
            chk("runMonRstLowCycles", 64'(lowCnt), 64'(r.len));
          end
          lowCnt = 0;
        end
        if (busy) busyCnt++;
        if (campaignDone && !prevDone) begin
          chk("campaignExpected", 64'(campQ.size() != 0), 64'd1);
          if (campQ.size() != 0) begin
            c = campQ.pop_front();
            chk("passMask", 64'(passMask), 64'(c.pass));
            chk("timeoutMask", 64'(timeoutMask), 64'(c.tmo));
            chk("sigCapture", 64'(sigCapture), 64'(c.sig));
            chk("busyCycles", 64'(busyCnt), 64'(c.busyCyc));
            chk("busyLowAtDone", 64'(busy), 64'd0);
          end
          busyCnt = 0;
        end
        prevDone = campaignDone;
      end
    end
  end

  task automatic expRun(input int sel, input int len);
    runT r;
    r.sel = sel; r.len = len;
    runQ.push_back(r);
  endtask

  task automatic expCamp(input logic [NC-1:0] p, input logic [NC-1:0] t, input logic [SW-1:0] s, input int b);
    campT c;
    c.pass = p; c.tmo = t; c.sig = s; c.busyCyc = b;
    campQ.push_back(c);
  endtask

  task automatic startCampaign(input logic [NC-1:0] m);
    @(negedge clk);
    start = 1'b1; coreMask = m;
    @(negedge clk);
    start = 1'b0; coreMask = ~m;
    chk("busyInCycle1", 64'(busy), 64'd1);
    chk("doneClearedByStart", 64'(campaignDone), 64'd0);
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while (!campaignDone && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("campaignDoneWithinBound", 64'(campaignDone), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic setAll(input int d);
    for (int i = 0; i < NC; i++) begin
      doneAt[i] = d;
      sigVal[i] = goldenSig[i*SW +: SW];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rstIn = 1'b1; start = 1'b0; coreMask = '0;
    goldenSig = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    setAll(60);
    #12;
    chk("rstMonRst", 64'(ifc.monRst), 64'd1);
    chk("rstCoreSel", 64'(ifc.coreSel), 64'd0);
    chk("rstBusy", 64'(busy), 64'd0);
    chk("rstDone", 64'(campaignDone), 64'd0);
    chk("rstPass", 64'(passMask), 64'd0);
    chk("rstTmo", 64'(timeoutMask), 64'd0);
    chk("rstSig", 64'(sigCapture), 64'd0);
    @(negedge clk);
    rstIn = 1'b0;

    // all cores pass after 60 RUN cycles; per core 1+2+60+1+1 = 65 busy cycles
    for (int i = 0; i < NC; i++) expRun(i, 61);
    expCamp(4'b1111, 4'b0000, 16'hDEF0, 260);
    startCampaign(4'b1111);
    repeat (100) @(negedge clk);
    start = 1'b1; coreMask = 4'b0000;   // must be ignored while busy
    @(negedge clk);
    start = 1'b0;
    waitDone(400);

    // cores 0 and 2 only, core 2 signature off by one bit
    sigVal[2] = 16'h9ABC ^ 16'h0001;
    expRun(0, 61); expRun(2, 61);
    expCamp(4'b0001, 4'b0000, 16'h9ABD, 132);
    startCampaign(4'b0101);
    waitDone(300);

    // core 1 never completes: RUN lasts TIMEOUT cycles, no capture
    setAll(0);
    expRun(1, TO);
    expCamp(4'b0000, 4'b0010, 16'h9ABD, 71);
    startCampaign(4'b0010);
    waitDone(200);

    // done arrives exactly in the timer = TIMEOUT-1 cycle
    setAll(0);
    doneAt[0] = TO; sigVal[0] = 16'h1234;
    expRun(0, TO + 1);
    expCamp(4'b0001, 4'b0000, 16'h1234, 72);
    startCampaign(4'b0001);
    waitDone(200);

    // empty mask: four SCAN cycles, monitor never leaves reset
    expCamp(4'b0000, 4'b0000, 16'h1234, 4);
    startCampaign(4'b0000);
    waitDone(20);

    // asynchronous reset during core 1 RUN
    setAll(10);
    expRun(0, 11);
    startCampaign(4'b1111);
    n = 0;
    while (!(ifc.coreSel == 2'd1 && !ifc.monRst) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reachedCore1Run", 64'(ifc.coreSel == 2'd1 && !ifc.monRst), 64'd1);
    repeat (3) @(posedge clk);
    #2 rstIn = 1'b1;
    #1;
    chk("abortMonRst", 64'(ifc.monRst), 64'd1);
    chk("abortCoreSel", 64'(ifc.coreSel), 64'd0);
    chk("abortBusy", 64'(busy), 64'd0);
    chk("abortDone", 64'(campaignDone), 64'd0);
    chk("abortPass", 64'(passMask), 64'd0);
    chk("abortTmo", 64'(timeoutMask), 64'd0);
    chk("abortSig", 64'(sigCapture), 64'd0);
    @(negedge clk);
    #2 rstIn = 1'b0;

    // fresh campaign after reset: 1 + 1 + 15 + 1 busy cycles
    expRun(2, 11);
    expCamp(4'b0100, 4'b0000, 16'h9ABC, 18);
    startCampaign(4'b0100);
    waitDone(100);

    repeat (5) @(negedge clk);
    chk("runQueueDrained", 64'(runQ.size()), 64'd0);
    chk("campQueueDrained", 64'(campQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
